alu_issue_stage: RTL

Execute-stage front end for the 16-bit datapath. It accepts decoded instructions from decode over a valid/ready handshake and holds them in an operand register (stage A). It resolves read-after-write hazards by forwarding, and drives the combinational ALU's `source1`/`source2`/`ALU_CTRL`. It captures the ALU result in a result register (stage B), which drains to writeback over a second valid/ready handshake.

---
 rtl/alu_issue_stage.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// Execute-stage front end: operand register (stage A) with forwarding,
// drives the external combinational ALU, result register (stage B) drains
// to writeback over a valid/ready handshake.
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [3:0]  id_opcode,
  input  logic [3:0]  id_funct,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic [2:0]  id_rd,
  input  logic [15:0] id_rs_data,
  input  logic [15:0] id_rt_data,
  input  logic [15:0] id_imm,
  output logic [15:0] alu_src1,
  output logic [15:0] alu_src2,
  output logic [3:0]  alu_ctrl,
  input  logic [15:0] alu_result,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [15:0] ex_result,
  output logic [2:0]  ex_rd,
  output logic        ex_illegal
);

  typedef struct packed {
    logic [3:0] ctrl;
    logic       illegal;
    logic       use_rt;
    logic       imm_src;
    logic [2:0] dest;
  } dec_t;

  // Map opcode/funct to ALU control, operand selection and destination.
  function automatic dec_t decode(input logic [3:0] opc, input logic [3:0] funct,
                                  input logic [2:0] rt, input logic [2:0] rd);
    dec_t d;
    d      = '0;
    d.dest = rd;
    if (opc == 4'b0000) begin
      d.use_rt = 1'b1;
      case (funct)
        4'b0000: d.ctrl = 4'd2;
        4'b0010: d.ctrl = 4'd6;
        4'b1010: d.ctrl = 4'd7;
        default: begin
          d.use_rt  = 1'b0;
          d.illegal = 1'b1;
        end
      endcase
    end else if (opc == 4'b0001) begin
      d.ctrl    = 4'd2;
      d.imm_src = 1'b1;
      d.dest    = rt;
    end else begin
      d.illegal = 1'b1;
    end
    return d;
  endfunction

  logic        vld_p0;
  logic [2:0]  rs_p0, rt_p0, dest_p0;
  logic [3:0]  ctrl_p0;
  logic        ill_p0, use_rt_p0;
  logic [15:0] op1_p0, op2_p0;

  logic  ex_retire, b_adv, a_adv, a_load;
  logic  ld_fwd1, ld_fwd2, sn_fwd1, sn_fwd2, byp1, byp2;
  dec_t  dec;

  assign ex_retire = ex_valid && ex_ready;
  assign b_adv     = !ex_valid || ex_ready;
  assign a_adv     = vld_p0 && b_adv;
  assign id_ready  = !vld_p0 || a_adv;
  assign a_load    = id_valid && id_ready;
  assign dec       = decode(id_opcode, id_funct, id_rt, id_rd);

  // A retiring write to r0 is never forwarded.
  assign ld_fwd1 = ex_retire && (ex_rd != 3'd0) && (ex_rd == id_rs);
  assign ld_fwd2 = ex_retire && (ex_rd != 3'd0) && (ex_rd == id_rt) && dec.use_rt;
  assign sn_fwd1 = vld_p0 && !a_adv && ex_retire && (ex_rd != 3'd0) && (ex_rd == rs_p0);
  assign sn_fwd2 = vld_p0 && !a_adv && ex_retire && (ex_rd != 3'd0) && (ex_rd == rt_p0) && use_rt_p0;
  assign byp1    = ex_valid && (ex_rd != 3'd0) && (ex_rd == rs_p0);
  assign byp2    = ex_valid && (ex_rd != 3'd0) && (ex_rd == rt_p0) && use_rt_p0;

  // ---- stage A: operand register ----
  // Stage A occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      vld_p0 <= 1'b0;
    else if (a_load) vld_p0 <= 1'b1;
    else if (a_adv)  vld_p0 <= 1'b0;
  end

  // Stage A payload: load with load-time bypass, or snoop a retiring write while holding.
  always_ff @(posedge clk) begin
    if (a_load) begin
      rs_p0     <= id_rs;
      rt_p0     <= id_rt;
      dest_p0   <= dec.dest;
      ctrl_p0   <= dec.ctrl;
      ill_p0    <= dec.illegal;
      use_rt_p0 <= dec.use_rt;
      op1_p0    <= ld_fwd1 ? ex_result : id_rs_data;
      op2_p0    <= dec.imm_src ? id_imm : (ld_fwd2 ? ex_result : id_rt_data);
    end else begin
      if (sn_fwd1) op1_p0 <= ex_result;
      if (sn_fwd2) op2_p0 <= ex_result;
    end
  end

  // ALU drive: B bypass beats A's stored operand; idle A presents zeros.
  always_comb begin
    alu_ctrl = 4'd0;
    alu_src1 = 16'd0;
    alu_src2 = 16'd0;
    if (vld_p0) begin
      alu_ctrl = ctrl_p0;
      alu_src1 = byp1 ? ex_result : op1_p0;
      alu_src2 = byp2 ? ex_result : op2_p0;
    end
  end

  // ---- stage B: result register ----
  // Capture the ALU result on advance; empty on retire without a replacement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_result  <= 16'd0;
      ex_rd      <= 3'd0;
      ex_illegal <= 1'b0;
    end else if (a_adv) begin
      ex_valid   <= 1'b1;
      ex_result  <= ill_p0 ? 16'd0 : alu_result;
      ex_rd      <= dest_p0;
      ex_illegal <= ill_p0;
    end else if (ex_ready) begin
      ex_valid   <= 1'b0;
    end
  end

endmodule
